ram_wait_ctrl: RTL and testbench

- Parametrised, clocked byte-addressable data memory for the ARM simulator datapath.
- Generalises the 256-byte RAM: configurable depth and wait-state latency, a full Enable/MFC handshake, and cancellation.
- Serves byte, halfword and word accesses in big-endian byte order.
- Sits between the CPU control unit (MAR/MDR path) and backing storage.

---
 rtl/ram_wait_ctrl.sv | 158 +++++++++++++++
 tb/tb_ram_wait_ctrl.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/ram_wait_ctrl.sv
// Byte-addressable big-endian data RAM with programmable wait states and an Enable/MFC handshake.
// Define ALIGN_CHECK_EN to abort misaligned halfword/word accesses instead of wrapping them.
module ram_wait_ctrl #(
  parameter int ADDR_W      = 8,
  parameter int WAIT_STATES = 2
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              Enable,
  input  logic              ReadWrite,
  input  logic [ADDR_W-1:0] Address,
  input  logic [31:0]       DataIn,
  input  logic [1:0]        DataSize,
  output logic [31:0]       DataOut,
  output logic              MFC,
  output logic              Busy,
  output logic              Abort
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} stateT;

  localparam logic [3:0] WaitLoad = 4'(WAIT_STATES);

  stateT             state, stateNext;
  logic [3:0]        waitCnt;
  logic [ADDR_W-1:0] addrQ;
  logic [31:0]       dataQ;
  logic [1:0]        sizeQ;
  logic              rwQ;
  logic              capture, complete, misaligned, wrEn, rdEn;
  logic [ADDR_W-1:0] addr0, addr1, addr2, addr3;
  logic [31:0]       rdWord;
  logic [7:0]        mem [2**ADDR_W];

  always_comb begin
    stateNext = state;
    capture   = 1'b0;
    complete  = 1'b0;
    case (state)
      IDLE: begin
        if (Enable) begin
          stateNext = WAIT;
          capture   = 1'b1;
        end
      end
      WAIT: begin
        // A dropped Enable cancels the request even on what would be the completion edge.
        if (!Enable) begin
          stateNext = IDLE;
        end else if (waitCnt == 4'd0) begin
          stateNext = DONE;
          complete  = 1'b1;
        end
      end
      DONE: begin
        if (!Enable) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state   <= IDLE;
      waitCnt <= 4'd0;
    end else begin
      state <= stateNext;
      if (capture) begin
        waitCnt <= WaitLoad;
      end else if (state == WAIT && waitCnt != 4'd0) begin
        waitCnt <= waitCnt - 4'd1;
      end
    end
  end

  assign MFC  = (state == DONE);
  assign Busy = (state == WAIT);

`ifdef ALIGN_CHECK_EN
  logic abortQ;

  always_comb begin
    misaligned = 1'b0;
    case (sizeQ)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = addrQ[0];
      default: misaligned = (addrQ[1:0] != 2'b00);
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      abortQ <= 1'b0;
    end else if (complete) begin
      abortQ <= misaligned;
    end else if (state == DONE && !Enable) begin
      abortQ <= 1'b0;
    end
  end

  assign Abort = abortQ;
`else
  assign misaligned = 1'b0;
  assign Abort      = 1'b0;
`endif

  assign wrEn = complete && !rwQ && !misaligned;
  assign rdEn = complete &&  rwQ && !misaligned;

  // Byte lanes wrap modulo the memory size.
  assign addr0 = addrQ;
  assign addr1 = addrQ + ADDR_W'(1);
  assign addr2 = addrQ + ADDR_W'(2);
  assign addr3 = addrQ + ADDR_W'(3);

  always_comb begin
    rdWord = {mem[addr0], mem[addr1], mem[addr2], mem[addr3]};
    case (sizeQ)
      2'b00:   rdWord = {24'b0, mem[addr0]};
      2'b01:   rdWord = {16'b0, mem[addr0], mem[addr1]};
      default: rdWord = {mem[addr0], mem[addr1], mem[addr2], mem[addr3]};
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      DataOut <= 32'b0;
    end else if (rdEn) begin
      DataOut <= rdWord;
    end
  end

  // Request capture and storage: data only, never reset.
  always_ff @(posedge Clk) begin
    if (capture) begin
      addrQ <= Address;
      dataQ <= DataIn;
      sizeQ <= DataSize;
      rwQ   <= ReadWrite;
    end
    if (wrEn) begin
      case (sizeQ)
        2'b00: mem[addr0] <= dataQ[7:0];
        2'b01: begin
          mem[addr0] <= dataQ[15:8];
          mem[addr1] <= dataQ[7:0];
        end
        default: begin
          mem[addr0] <= dataQ[31:24];
          mem[addr1] <= dataQ[23:16];
          mem[addr2] <= dataQ[15:8];
          mem[addr3] <= dataQ[7:0];
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_wait_ctrl.sv
// Directed bench for ram_wait_ctrl (ADDR_W=8, WAIT_STATES=2); ALIGN_CHECK_EN adds the abort case.
module tb_ram_wait_ctrl;

  logic        Clk, Reset_n, Enable, ReadWrite;
  logic [7:0]  Address;
  logic [31:0] DataIn;
  logic [1:0]  DataSize;
  logic [31:0] DataOut;
  logic        MFC, Busy, Abort;

  int nChecks = 0;
  int nFail   = 0;

  ram_wait_ctrl #(.ADDR_W(8), .WAIT_STATES(2)) dut (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .Enable   (Enable),
    .ReadWrite(ReadWrite),
    .Address  (Address),
    .DataIn   (DataIn),
    .DataSize (DataSize),
    .DataOut  (DataOut),
    .MFC      (MFC),
    .Busy     (Busy),
    .Abort    (Abort)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One full handshake; inputs are scrambled after capture to show the latched copies are used.
  task automatic xfer(input logic rw, input logic [7:0] addr, input logic [31:0] din,
                      input logic [1:0] sz, output logic [31:0] dout, output int lat,
                      output logic abt);
    @(negedge Clk);
    Enable = 1'b1; ReadWrite = rw; Address = addr; DataIn = din; DataSize = sz;
    @(posedge Clk); #1;
    Address = ~addr; DataIn = ~din; DataSize = ~sz; ReadWrite = ~rw;
    lat = 0;
    while (!MFC && lat < 50) begin
      @(posedge Clk); #1;
      lat++;
    end
    dout = DataOut;
    abt  = Abort;
    @(negedge Clk);
    Enable = 1'b0;
    @(posedge Clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, prevRd;
    logic        abt;
    int          lat, bad;

    Reset_n = 1'b0; Enable = 1'b0; ReadWrite = 1'b0;
    Address = 8'h00; DataIn = 32'h0; DataSize = 2'b00;
    #22;
    chk("rst_dout", DataOut, 32'h0);
    chk("rst_mfc", {31'b0, MFC}, 32'h0);
    chk("rst_busy", {31'b0, Busy}, 32'h0);
    chk("rst_abort", {31'b0, Abort}, 32'h0);
    @(negedge Clk);
    Reset_n = 1'b1;

    // Idle with Enable low: nothing may start
    xfer(1'b0, 8'h00, 32'h0000005A, 2'b00, rd, lat, abt);
    @(negedge Clk);
    Enable = 1'b0; ReadWrite = 1'b0; Address = 8'h00; DataIn = 32'hFFFFFFFF; DataSize = 2'b00;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge Clk); #1;
      if (MFC || Busy) bad++;
    end
    chk("idle_quiet", bad, 0);
    xfer(1'b1, 8'h00, 32'h0, 2'b00, rd, lat, abt);
    chk("idle_rd0", rd, 32'h0000005A);

    // Byte write/read and latency
    xfer(1'b0, 8'h00, 32'hFFFFFF0B, 2'b00, rd, lat, abt);
    chk("wr_lat", lat, 3);
    chk("wr_keeps_dout", rd, 32'h0000005A);
    chk("wr_mfc_clear", {31'b0, MFC}, 32'h0);
    xfer(1'b1, 8'h00, 32'h0, 2'b00, rd, lat, abt);
    chk("rd_lat", lat, 3);
    chk("rd_byte0", rd, 32'h0000000B);

    // Halfword big-endian
    xfer(1'b0, 8'hF0, 32'hABCDEF1A, 2'b01, rd, lat, abt);
    xfer(1'b1, 8'hF0, 32'h0, 2'b01, rd, lat, abt);
    chk("rd_half_f0", rd, 32'h0000EF1A);
    xfer(1'b1, 8'hF0, 32'h0, 2'b00, rd, lat, abt);
    chk("rd_byte_f0", rd, 32'h000000EF);
    xfer(1'b1, 8'hF1, 32'h0, 2'b00, rd, lat, abt);
    chk("rd_byte_f1", rd, 32'h0000001A);

    // Word at top of memory, then wrapping word
    xfer(1'b0, 8'hFC, 32'hABCDEF1C, 2'b10, rd, lat, abt);
    xfer(1'b1, 8'hFC, 32'h0, 2'b10, rd, lat, abt);
    chk("rd_word_fc", rd, 32'hABCDEF1C);
`ifndef ALIGN_CHECK_EN
    xfer(1'b0, 8'hFE, 32'h11223344, 2'b10, rd, lat, abt);
    chk("abort_tied", {31'b0, abt}, 32'h0);
    xfer(1'b1, 8'hFE, 32'h0, 2'b11, rd, lat, abt);
    chk("rd_word_wrap", rd, 32'h11223344);
    xfer(1'b1, 8'h00, 32'h0, 2'b00, rd, lat, abt);
    chk("rd_wrap_byte0", rd, 32'h00000033);
`endif

    // Cancellation after one WAIT edge
    xfer(1'b0, 8'h10, 32'h01020304, 2'b10, rd, lat, abt);
    xfer(1'b0, 8'h20, 32'h0A0B0C0D, 2'b10, rd, lat, abt);
    xfer(1'b1, 8'hF0, 32'h0, 2'b01, prevRd, lat, abt);
    @(negedge Clk);
    Enable = 1'b1; ReadWrite = 1'b0; Address = 8'h10; DataIn = 32'hDEADBEEF; DataSize = 2'b10;
    @(posedge Clk); #1;
    chk("cancel_busy", {31'b0, Busy}, 32'h1);
    @(posedge Clk); #1;
    @(negedge Clk);
    Enable = 1'b0;
    @(posedge Clk); #1;
    chk("cancel_idle", {30'b0, MFC, Busy}, 32'h0);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge Clk); #1;
      if (MFC) bad++;
    end
    chk("cancel_no_mfc", bad, 0);
    chk("cancel_dout", DataOut, prevRd);
    xfer(1'b1, 8'h10, 32'h0, 2'b10, rd, lat, abt);
    chk("cancel_mem", rd, 32'h01020304);

    // Reset pulse mid-WAIT of a write
    @(negedge Clk);
    Enable = 1'b1; ReadWrite = 1'b0; Address = 8'h20; DataIn = 32'hCAFEBABE; DataSize = 2'b10;
    @(posedge Clk); #1;
    @(posedge Clk); #3;
    Reset_n = 1'b0;
    #1;
    chk("midrst_dout", DataOut, 32'h0);
    chk("midrst_flags", {29'b0, MFC, Busy, Abort}, 32'h0);
    @(negedge Clk);
    Enable = 1'b0;
    Reset_n = 1'b1;
    @(posedge Clk); #1;
    xfer(1'b1, 8'h20, 32'h0, 2'b10, rd, lat, abt);
    chk("midrst_mem", rd, 32'h0A0B0C0D);

`ifdef ALIGN_CHECK_EN
    xfer(1'b1, 8'h02, 32'h0, 2'b10, rd, lat, abt);
    chk("mis_lat", lat, 3);
    chk("mis_abort", {31'b0, abt}, 32'h1);
    chk("mis_dout", rd, 32'h0A0B0C0D);
    chk("mis_abort_clr", {31'b0, Abort}, 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
